text_buffer_writer: RTL



---
 rtl/text_buffer_pkg.sv | 32 +++
 rtl/text_buffer_ram.sv | 26 ++
 rtl/text_buffer_writer.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/text_buffer_pkg.sv
// rtl/text_buffer_pkg.sv - shared states, control codes and window geometry for the text buffer
package text_buffer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_SCROLL,
    ST_CLRROW
  } state_t;

  localparam logic [6:0] CH_BS    = 7'h08;
  localparam logic [6:0] CH_LF    = 7'h0A;
  localparam logic [6:0] CH_FF    = 7'h0C;
  localparam logic [6:0] CH_CR    = 7'h0D;
  localparam logic [6:0] CH_SPACE = 7'h20;
  localparam logic [6:0] CH_TILDE = 7'h7E;

  localparam int COLS = 32;
  localparam int ROWS = 4;

  localparam logic [9:0] WIN_X0 = 10'd192;
  localparam logic [9:0] WIN_Y0 = 10'd208;
  localparam logic [9:0] WIN_W  = 10'd256;
  localparam logic [9:0] WIN_H  = 10'd64;

  localparam logic [6:0] LAST_IDX    = 7'd127;
  localparam logic [6:0] SCROLL_LAST = 7'd95;
  localparam logic [6:0] ROW_STRIDE  = 7'd32;
  localparam logic [4:0] LAST_COL    = 5'd31;
  localparam logic [1:0] LAST_ROW    = 2'd3;

endpackage

// File: rtl/text_buffer_ram.sv
// rtl/text_buffer_ram.sv - 128x7 character store, one write port and two asynchronous read ports
module text_buffer_ram
  import text_buffer_pkg::*;
(
  input  logic       clk,
  input  logic       i_we,
  input  logic [6:0] i_waddr,
  input  logic [6:0] i_wdata,
  input  logic [6:0] i_raddr_a,
  input  logic [6:0] i_raddr_b,
  output logic [6:0] o_rdata_a,
  output logic [6:0] o_rdata_b
);

  logic [6:0] r_mem [COLS*ROWS];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = r_mem[i_raddr_a];
  assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/text_buffer_writer.sv
// rtl/text_buffer_writer.sv - cursor engine that fills, scrolls and clears the on-screen text buffer
module text_buffer_writer
  import text_buffer_pkg::*;
#(
  parameter logic [9:0] X0 = WIN_X0,
  parameter logic [9:0] Y0 = WIN_Y0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [9:0] x,
  input  logic [9:0] y,
  output logic [6:0] ascii_code,
  output logic [4:0] cursor_col,
  output logic [1:0] cursor_row,
  output logic       busy
);

  state_t     r_state, w_state_nxt;
  logic [6:0] r_idx, w_idx_nxt;
  logic [4:0] r_col, w_col_nxt;
  logic [1:0] r_row, w_row_nxt;
  logic [6:0] r_ascii;

  logic       w_we;
  logic [6:0] w_waddr, w_wdata;
  logic [6:0] w_scroll_raddr, w_scroll_rdata;
  logic [6:0] w_disp_addr, w_disp_rdata;
  logic       w_in_win;
  logic [4:0] w_col_d;
  logic [1:0] w_row_d;
  logic       w_accept;
  logic [6:0] w_code;
  logic       w_printable;

  assign in_ready    = (r_state == ST_IDLE) && rst_n;
  assign busy        = (r_state != ST_IDLE);
  assign w_code      = in_data[6:0];
  // Bytes with bit 7 set still complete the handshake but have no effect.
  assign w_accept    = in_valid && in_ready && !in_data[7];
  assign w_printable = (w_code >= CH_SPACE) && (w_code <= CH_TILDE);
  assign w_scroll_raddr = r_idx + ROW_STRIDE;

  assign w_in_win = (x >= X0) && (x < X0 + WIN_W) && (y >= Y0) && (y < Y0 + WIN_H);
  assign w_col_d  = 5'((x - X0) >> 3);
  assign w_row_d  = 2'((y - Y0) >> 4);
  assign w_disp_addr = {w_row_d, w_col_d};

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_col_nxt   = r_col;
    w_row_nxt   = r_row;
    w_we        = 1'b0;
    w_waddr     = {r_row, r_col};
    w_wdata     = CH_SPACE;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_printable) begin
            w_we    = 1'b1;
            w_wdata = w_code;
            if (r_col == LAST_COL) begin
              w_col_nxt = 5'd0;
              if (r_row == LAST_ROW) begin
                w_state_nxt = ST_SCROLL;
                w_idx_nxt   = 7'd0;
              end else begin
                w_row_nxt = r_row + 2'd1;
              end
            end else begin
              w_col_nxt = r_col + 5'd1;
            end
          end else if (w_code == CH_LF || w_code == CH_CR) begin
            w_col_nxt = 5'd0;
            if (r_row == LAST_ROW) begin
              w_state_nxt = ST_SCROLL;
              w_idx_nxt   = 7'd0;
            end else begin
              w_row_nxt = r_row + 2'd1;
            end
          end else if (w_code == CH_BS) begin
            if (r_col != 5'd0) begin
              w_col_nxt = r_col - 5'd1;
              w_we      = 1'b1;
              w_waddr   = {r_row, r_col - 5'd1};
            end else if (r_row != 2'd0) begin
              w_col_nxt = LAST_COL;
              w_row_nxt = r_row - 2'd1;
              w_we      = 1'b1;
              w_waddr   = {r_row - 2'd1, LAST_COL};
            end
          end else if (w_code == CH_FF) begin
            w_col_nxt   = 5'd0;
            w_row_nxt   = 2'd0;
            w_state_nxt = ST_CLEAR;
            w_idx_nxt   = 7'd0;
          end
        end
      end
      ST_CLEAR: begin
        w_we      = 1'b1;
        w_waddr   = r_idx;
        w_idx_nxt = r_idx + 7'd1;
        if (r_idx == LAST_IDX) w_state_nxt = ST_IDLE;
      end
      ST_SCROLL: begin
        w_we      = 1'b1;
        w_waddr   = r_idx;
        w_wdata   = w_scroll_rdata;
        w_idx_nxt = r_idx + 7'd1;
        if (r_idx == SCROLL_LAST) w_state_nxt = ST_CLRROW;
      end
      ST_CLRROW: begin
        w_we      = 1'b1;
        w_waddr   = r_idx;
        w_idx_nxt = r_idx + 7'd1;
        if (r_idx == LAST_IDX) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_CLEAR;
      r_idx   <= 7'd0;
      r_col   <= 5'd0;
      r_row   <= 2'd0;
      r_ascii <= CH_SPACE;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_col   <= w_col_nxt;
      r_row   <= w_row_nxt;
      r_ascii <= w_in_win ? w_disp_rdata : CH_SPACE;
    end
  end

  text_buffer_ram u_ram (
    .clk       (clk),
    .i_we      (w_we && rst_n),
    .i_waddr   (w_waddr),
    .i_wdata   (w_wdata),
    .i_raddr_a (w_disp_addr),
    .i_raddr_b (w_scroll_raddr),
    .o_rdata_a (w_disp_rdata),
    .o_rdata_b (w_scroll_rdata)
  );

  assign ascii_code = r_ascii;
  assign cursor_col = r_col;
  assign cursor_row = r_row;

endmodule
